// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - received-byte bundle from uart_rx to a byte consumer
interface uart_rx_if;
  logic [7:0] RX_DOUT;
  logic       RX_DONE;
  logic       RX_FRAME_ERR;
  logic       RX_BUSY;

  modport master (output RX_DOUT, output RX_DONE, output RX_FRAME_ERR, output RX_BUSY);
  modport slave  (input  RX_DOUT, input  RX_DONE, input  RX_FRAME_ERR, input  RX_BUSY);
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit sampling and runtime bit period
// Bit period is max(CLKDIV, 4) clocks, latched at start detection for the whole frame.
module uart_rx (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] CLKDIV,
  input  logic        RX_SERIAL,
  uart_rx_if.master   rx
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state;
  logic        s1, s2, s2_d;
  logic [15:0] cnt;
  logic [15:0] div_q;
  logic [2:0]  idx;
  logic [7:0]  shreg;
  logic [7:0]  dout_q;
  logic        done_q;
  logic        err_q;

  logic [15:0] d_eff;
  logic [15:0] half;

  assign d_eff = (CLKDIV < 16'd4) ? 16'd4 : CLKDIV;
  assign half  = {1'b0, div_q[15:1]};

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      s1     <= 1'b1;
      s2     <= 1'b1;
      s2_d   <= 1'b1;
      cnt    <= 16'd0;
      div_q  <= 16'd4;
      idx    <= 3'd0;
      shreg  <= 8'd0;
      dout_q <= 8'd0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      s1     <= RX_SERIAL;
      s2     <= s1;
      s2_d   <= s2;
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          // Falling edge only, so a line stuck low after a framing error cannot retrigger
          if (!s2 && s2_d) begin
            state <= START;
            cnt   <= 16'd0;
            div_q <= d_eff;
          end
        end
        START: begin
          if (cnt == half - 16'd1) begin
            cnt <= 16'd0;
            idx <= 3'd0;
            state <= s2 ? IDLE : DATA;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        DATA: begin
          if (cnt == div_q - 16'd1) begin
            cnt        <= 16'd0;
            shreg[idx] <= s2;
            if (idx == 3'd7) state <= STOP;
            else             idx   <= idx + 3'd1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        STOP: begin
          // Leave at mid-stop-bit so a start bit right after the stop bit is still caught
          if (cnt == div_q - 16'd1) begin
            cnt    <= 16'd0;
            dout_q <= shreg;
            err_q  <= ~s2;
            done_q <= 1'b1;
            state  <= IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rx.RX_DOUT      = dout_q;
  assign rx.RX_DONE      = done_q;
  assign rx.RX_FRAME_ERR = err_q;
  assign rx.RX_BUSY      = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx
module tb_uart_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] clkdiv = 16'd16;
  logic        rx_serial = 1'b1;

  uart_rx_if rx ();

  uart_rx dut (
    .CLK       (clk),
    .RST       (rst),
    .CLKDIV    (clkdiv),
    .RX_SERIAL (rx_serial),
    .rx        (rx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         tests = 0;
  int         fails = 0;
  int         t0 = 0;
  int         done_q[$];
  logic [7:0] dout_q[$];
  logic       err_q[$];
  int         busy_rise = 0;
  int         busy_fall = 0;
  logic       busy_prev = 1'b0;

  always @(negedge clk) begin
    if (rx.RX_DONE === 1'b1) begin
      done_q.push_back(cyc);
      dout_q.push_back(rx.RX_DOUT);
      err_q.push_back(rx.RX_FRAME_ERR);
    end
    if (rx.RX_BUSY === 1'b1 && !busy_prev) busy_rise = cyc;
    if (rx.RX_BUSY === 1'b0 && busy_prev)  busy_fall = cyc;
    busy_prev = (rx.RX_BUSY === 1'b1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_q();
    done_q.delete();
    dout_q.delete();
    err_q.delete();
  endtask

  // Caller is at a negedge; t0 is the next posedge, where s1 first captures the start bit
  task automatic send_frame(input logic [7:0] b, input int p, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    t0 = cyc + 1;
    for (int i = 0; i < 10; i++) begin
      rx_serial = bits[i];
      repeat (p) @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    rx_serial = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_strobes(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (done_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({name, "_strobe_cnt"}, done_q.size(), n);
  endtask

  task automatic expect_frame(input string name, input logic [7:0] d, input logic e, input int lat);
    wait_strobes(1, 400, name);
    if (done_q.size() > 0) begin
      check({name, "_lat"},  done_q[0] - t0, lat);
      check({name, "_dout"}, dout_q[0], d);
      check({name, "_err"},  err_q[0], e);
    end
    clear_q();
  endtask

  typedef struct {
    logic [15:0] clkdiv;
    int          period;
    logic [7:0]  data;
    logic        stop;
    logic [7:0]  exp_dout;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{16'd16, 16, 8'hA5, 1'b1, 8'hA5, 1'b0, 154};
    vecs[1] = '{16'd2,   4, 8'h96, 1'b1, 8'h96, 1'b0, 40};
    vecs[2] = '{16'd4,   4, 8'h00, 1'b1, 8'h00, 1'b0, 40};
    vecs[3] = '{16'd10, 10, 8'h81, 1'b1, 8'h81, 1'b0, 97};
    vecs[4] = '{16'd7,   7, 8'hE1, 1'b1, 8'hE1, 1'b0, 68};
    vecs[5] = '{16'd12, 12, 8'h55, 1'b0, 8'h55, 1'b1, 116};
    vecs[6] = '{16'd16, 16, 8'hFF, 1'b1, 8'hFF, 1'b0, 154};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_dout", rx.RX_DOUT, 8'h00);
    check("rst_done", rx.RX_DONE, 1'b0);
    check("rst_err",  rx.RX_FRAME_ERR, 1'b0);
    check("rst_busy", rx.RX_BUSY, 1'b0);
    rst = 1'b0;
    idle(5);

    for (int i = 0; i < 7; i++) begin
      clkdiv = vecs[i].clkdiv;
      idle(3);
      send_frame(vecs[i].data, vecs[i].period, vecs[i].stop);
      idle(20);
      wait_strobes(1, 400, $sformatf("vec%0d", i));
      if (done_q.size() > 0) begin
        check($sformatf("vec%0d_lat", i), done_q[0] - t0, vecs[i].exp_lat);
        check($sformatf("vec%0d_dout", i), dout_q[0], vecs[i].exp_dout);
        check($sformatf("vec%0d_err", i), err_q[0], vecs[i].exp_err);
        check($sformatf("vec%0d_busy_rise", i), busy_rise - t0, 2);
        check($sformatf("vec%0d_busy_fall", i), busy_fall, done_q[0]);
        check($sformatf("vec%0d_single", i), done_q.size(), 1);
      end
      clear_q();
    end

    // Back-to-back frames with no idle gap
    clkdiv = 16'd16;
    idle(5);
    send_frame(8'h00, 16, 1'b1);
    send_frame(8'hFF, 16, 1'b1);
    idle(30);
    wait_strobes(2, 400, "b2b");
    if (done_q.size() >= 2) begin
      check("b2b_spacing", done_q[1] - done_q[0], 160);
      check("b2b_dout0", dout_q[0], 8'h00);
      check("b2b_dout1", dout_q[1], 8'hFF);
      check("b2b_err", {err_q[0], err_q[1]}, 2'b00);
    end
    clear_q();

    // Short low glitch
    rx_serial = 1'b0;
    t0 = cyc + 1;
    repeat (3) @(negedge clk);
    idle(40);
    check("glitch_no_strobe", done_q.size(), 0);
    check("glitch_busy_rise", busy_rise - t0, 2);
    check("glitch_busy_len", busy_fall - busy_rise, 8);
    check("glitch_idle", rx.RX_BUSY, 1'b0);
    send_frame(8'h5A, 16, 1'b1);
    idle(20);
    expect_frame("post_glitch", 8'h5A, 1'b0, 154);

    // Framing error with line held low afterwards
    clkdiv = 16'd10;
    idle(5);
    send_frame(8'h3C, 10, 1'b0);
    repeat (50) @(negedge clk);
    check("ferr_strobes", done_q.size(), 1);
    if (done_q.size() > 0) begin
      check("ferr_dout", dout_q[0], 8'h3C);
      check("ferr_err", err_q[0], 1'b1);
    end
    clear_q();
    idle(30);
    check("ferr_no_retrigger", done_q.size(), 0);
    send_frame(8'h81, 10, 1'b1);
    idle(20);
    expect_frame("ferr_recover", 8'h81, 1'b0, 97);

    // Reset during data bit 4
    clkdiv = 16'd16;
    idle(5);
    fork
      send_frame(8'hF0, 16, 1'b1);
      begin
        repeat (88) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", rx.RX_BUSY, 1'b0);
        check("midrst_dout", rx.RX_DOUT, 8'h00);
      end
    join
    idle(40);
    check("midrst_no_strobe", done_q.size(), 0);
    clear_q();
    send_frame(8'hC3, 16, 1'b1);
    idle(20);
    expect_frame("post_rst", 8'hC3, 1'b0, 154);

    // CLKDIV change mid-frame keeps the latched period
    clkdiv = 16'd16;
    idle(5);
    fork
      send_frame(8'h37, 16, 1'b1);
      begin
        repeat (40) @(negedge clk);
        clkdiv = 16'd8;
      end
    join
    idle(20);
    expect_frame("div_change", 8'h37, 1'b0, 154);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
